hcp_rd_rsp: RTL and testbench
=============================

// Module: hcp_rd_rsp
// PURPOSE
//  Read-response framer downstream of the HCP command parser. Accepts a read command (start address, word
//  count), fetches 32-bit words from port B of the shared w32d64 register RAM, and emits a TSMP read-response
//  frame as a 9-bit byte stream (bit8 = start-of-frame) toward the egress MAC path. Supports downstream backpressure.
// PARAMETERS
//  DATA_WIDTH      9   stream word width; bit DATA_WIDTH-1 flags first byte of frame, bits 7:0 payload
//  RAM_ADDR_WIDTH  6   RAM address width (64 words)
//  RAM_RD_LATENCY  2   cycles from o_ram_rden to valid iv_ram_q (1 or 2 supported)
// PORTS
//  i_clk          in   1   system clock
//  i_rst          in   1   synchronous reset, active-high
//  i_rd_req       in   1   read command strobe, one cycle
//  iv_rd_addr     in   6   start word address
//  iv_rd_num      in   6   word count; 0 = header-only frame
//  o_busy         out  1   frame in progress; i_rd_req ignored while high
//  o_req_drop     out  1   one-cycle pulse: i_rd_req arrived while o_busy
//  ov_ram_addr    out  6   RAM port B address
//  o_ram_rden     out  1   RAM port B read enable
//  iv_ram_q       in   32  RAM port B read data
//  ov_data        out  9   response byte stream
//  o_data_wr      out  1   ov_data valid
//  i_ready        in   1   downstream accepts; byte transfers when o_data_wr && i_ready
// BEHAVIOUR
//  - Clock i_clk, one domain; reset synchronous active-high (i_rst). Reset: all outputs 0, FSM IDLE, buffer empty, counters 0.
//  - FSM: IDLE -> HDR -> DATA -> (TRL if HCP_RSP_CSUM_EN) -> IDLE. HDR skips DATA when num=0.
//  - IDLE: i_rd_req latches addr/num, o_busy=1 next cycle. Request at cycle T -> first header byte on ov_data at T+1.
//  - HDR: 3 bytes {1'b1,8'h02(TSMP_TYPE_RDRSP)}, {1'b0,2'b0,addr}, {1'b0,2'b0,num}. Only first byte of frame has bit8=1.
//  - DATA: per word, 4 bytes MSB first (q[31:24] first), bit8=0; then next word. 4*num data bytes total.
//  - RAM fetch: reads issued from T+1 onward, address increments per read, wraps 63->0; read issued only when
//    (buffered words + reads in flight) < 2. With RAM_RD_LATENCY=2 and i_ready held high, no idle cycle in frame.
//  - Handshake: ov_data/o_data_wr stable while o_data_wr && !i_ready; advance only on transfer. o_data_wr may rise
//    without waiting for i_ready; never drops until byte transfers.
//  - Frame ends on transfer of last byte; o_busy falls the following cycle; new i_rd_req accepted that same cycle.
//  - i_rd_req same cycle as last-byte transfer: dropped (o_busy still high), o_req_drop=1.
//  - Reset mid-frame: frame truncated, no trailer; downstream resynchronises on next bit8=1. In-flight RAM data discarded.
//  - iv_rd_num > 0 with addr+num > 64: wrap, no error.
// CONFIGURATION
//  - HCP_RSP_CSUM_EN defined: TRL state appends one byte {1'b0, XOR of all 8-bit payloads in frame incl. header}.
//    Frame length 3+4*num+1.
//  - Undefined: no TRL state, no checksum logic; frame length 3+4*num.
// STRUCTURE
//  - Shared header hcp_defs.vh: TSMP_TYPE_READ 8'h00, TSMP_TYPE_WRITE 8'h01, TSMP_TYPE_RDRSP 8'h02,
//    TSMP_TYPE_CONFIG 8'h16, HCP_DATA_WIDTH 9, HCP_RAM_ADDR_WIDTH 6. Used by hcp and hcp_rd_rsp.
//  - Sub-module hcp_rsp_word_buf: 2-entry 32-bit FIFO (push from RAM-latency pipe, pop per 4 bytes sent,
//    count output). Latency shift register and byte mux stay in top.
// TESTING
//  1. addr=5,num=1, i_ready=1: bytes 0x102,0x005,0x001 then RAM[5] MSB-first at T+1..T+7; o_busy low at T+8.
//  2. addr=62,num=4: reads addresses 62,63,0,1; 19 bytes; checks wrap and no bubble with i_ready=1.
//  3. num=0: exactly 3 bytes 0x102,addr,0x000; no o_ram_rden pulse.
//  4. i_ready random 50%, num=8: ov_data stable during stalls, byte sequence matches memory model, never >2 reads outstanding.
//  5. i_rd_req during busy and on last-byte cycle: o_req_drop=1, frame unaffected; request next cycle accepted.
//  6. i_rst during byte 6 of num=3 frame: outputs 0 next cycle; new request yields correct complete frame
//     (with HCP_RSP_CSUM_EN: trailer = XOR check, e.g. header 02,00,01 + data 00000000 -> 0x03).

Source files
------------

// File: rtl/hcp_rd_rsp_pkg.sv
// hcp_rd_rsp_pkg: shared HCP frame constants and read-response framer state encoding
package hcp_rd_rsp_pkg;
    localparam logic [7:0] TSMP_TYPE_READ   = 8'h00;
    localparam logic [7:0] TSMP_TYPE_WRITE  = 8'h01;
    localparam logic [7:0] TSMP_TYPE_RDRSP  = 8'h02;
    localparam logic [7:0] TSMP_TYPE_CONFIG = 8'h16;
    localparam int HCP_DATA_WIDTH     = 9;
    localparam int HCP_RAM_ADDR_WIDTH = 6;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
`ifdef HCP_RSP_CSUM_EN
        , ST_TRL
`endif
    } rsp_state_t;
endpackage

// File: rtl/hcp_rsp_word_buf.sv
// hcp_rsp_word_buf: two-entry word FIFO between the RAM read pipe and the byte mux
module hcp_rsp_word_buf (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] iv_din,
    output logic [31:0] ov_dout,
    output logic [1:0]  ov_cnt
);
    logic [31:0] mem [2];
    logic        wp, rp;
    assign ov_dout = mem[rp];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            ov_cnt <= 2'd0;
        end else begin
            if (i_push) begin
                mem[wp] <= iv_din;
                wp      <= ~wp;
            end
            if (i_pop) rp <= ~rp;
            ov_cnt <= ov_cnt + 2'(i_push) - 2'(i_pop);
        end
    end
endmodule

// File: rtl/hcp_rd_rsp.sv
// hcp_rd_rsp: TSMP read-response framer from port-B RAM words; define HCP_RSP_CSUM_EN to append an XOR trailer byte
module hcp_rd_rsp
    import hcp_rd_rsp_pkg::*;
#(
    parameter int DATA_WIDTH     = HCP_DATA_WIDTH,
    parameter int RAM_ADDR_WIDTH = HCP_RAM_ADDR_WIDTH,
    parameter int RAM_RD_LATENCY = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rd_req,
    input  logic [RAM_ADDR_WIDTH-1:0] iv_rd_addr,
    input  logic [RAM_ADDR_WIDTH-1:0] iv_rd_num,
    output logic                      o_busy,
    output logic                      o_req_drop,
    output logic [RAM_ADDR_WIDTH-1:0] ov_ram_addr,
    output logic                      o_ram_rden,
    input  logic [31:0]               iv_ram_q,
    output logic [DATA_WIDTH-1:0]     ov_data,
    output logic                      o_data_wr,
    input  logic                      i_ready
);
    rsp_state_t                state;
    logic [RAM_ADDR_WIDTH-1:0] addr_r, num_r, rd_left, words_left;
    logic [1:0]                hidx, bidx, cnt;
    logic [RAM_RD_LATENCY-1:0] lat_sr;
    logic [31:0]               head, word;
    logic [7:0]                dbyte;
    logic                      xfer, adv, q_vld, w_vld, dsel, ld_data, pop, fin, done;
    hcp_rsp_word_buf u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (q_vld),
        .i_pop   (pop),
        .iv_din  (iv_ram_q),
        .ov_dout (head),
        .ov_cnt  (cnt)
    );
    // An empty buffer lets the word arriving from RAM feed its first byte directly, avoiding a bubble after the header.
    always_comb begin
        xfer       = o_data_wr && i_ready;
        adv        = !o_data_wr || i_ready;
        q_vld      = lat_sr[RAM_RD_LATENCY-1];
        w_vld      = cnt != 2'd0 || q_vld;
        word       = cnt != 2'd0 ? head : iv_ram_q;
        dbyte      = bidx == 2'd0 ? word[31:24] : bidx == 2'd1 ? word[23:16] : bidx == 2'd2 ? word[15:8] : word[7:0];
        dsel       = state == ST_DATA ? adv && words_left != '0 : state == ST_HDR && hidx == 2'd2 && xfer && num_r != '0;
        fin        = state == ST_DATA ? adv && words_left == '0 : state == ST_HDR && hidx == 2'd2 && xfer && num_r == '0;
        ld_data    = dsel && w_vld;
        pop        = ld_data && bidx == 2'd3;
        o_ram_rden = o_busy && rd_left != '0 && int'(cnt) + $countones(lat_sr) < 2;
`ifdef HCP_RSP_CSUM_EN
        done       = state == ST_TRL && xfer;
`else
        done       = fin;
`endif
    end
`ifdef HCP_RSP_CSUM_EN
    logic [7:0] csum;
    always_ff @(posedge i_clk) begin
        if (i_rst || state == ST_IDLE) csum <= 8'h00;
        else if (xfer) csum <= csum ^ ov_data[7:0];
    end
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_busy      <= 1'b0;
            o_req_drop  <= 1'b0;
            o_data_wr   <= 1'b0;
            ov_data     <= '0;
            ov_ram_addr <= '0;
            addr_r      <= '0;
            num_r       <= '0;
            rd_left     <= '0;
            words_left  <= '0;
            hidx        <= 2'd0;
            bidx        <= 2'd0;
            lat_sr      <= '0;
        end else begin
            o_req_drop <= i_rd_req && o_busy;
            lat_sr     <= (lat_sr << 1) | RAM_RD_LATENCY'(o_ram_rden);
            if (o_ram_rden) begin
                ov_ram_addr <= ov_ram_addr + RAM_ADDR_WIDTH'(1);
                rd_left     <= rd_left - RAM_ADDR_WIDTH'(1);
            end
            if (state == ST_IDLE) begin
                if (i_rd_req) begin
                    state       <= ST_HDR;
                    o_busy      <= 1'b1;
                    o_data_wr   <= 1'b1;
                    ov_data     <= {1'b1, TSMP_TYPE_RDRSP};
                    addr_r      <= iv_rd_addr;
                    num_r       <= iv_rd_num;
                    ov_ram_addr <= iv_rd_addr;
                    rd_left     <= iv_rd_num;
                    words_left  <= iv_rd_num;
                    hidx        <= 2'd0;
                    bidx        <= 2'd0;
                end
            end else if (done) begin
                state     <= ST_IDLE;
                o_busy    <= 1'b0;
                o_data_wr <= 1'b0;
                ov_data   <= '0;
            end
`ifdef HCP_RSP_CSUM_EN
            else if (fin) begin
                state   <= ST_TRL;
                ov_data <= {1'b0, csum ^ ov_data[7:0]};
            end
`endif
            else if (dsel) begin
                state     <= ST_DATA;
                o_data_wr <= w_vld;
                if (ld_data) begin
                    ov_data <= {1'b0, dbyte};
                    bidx    <= bidx + 2'd1;
                    if (bidx == 2'd3) words_left <= words_left - RAM_ADDR_WIDTH'(1);
                end
            end else if (state == ST_HDR && xfer) begin
                ov_data <= {1'b0, {(8-RAM_ADDR_WIDTH){1'b0}}, hidx == 2'd0 ? addr_r : num_r};
                hidx    <= hidx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_hcp_rd_rsp.sv
// tb_hcp_rd_rsp: scoreboard bench for the read-response framer with a two-cycle RAM model
module tb_hcp_rd_rsp;
    logic        clk = 1'b0;
    logic        rst, i_rd_req, i_ready;
    logic [5:0]  iv_rd_addr, iv_rd_num, ov_ram_addr;
    logic        o_busy, o_req_drop, o_ram_rden, o_data_wr;
    logic [31:0] iv_ram_q, ram_r1;
    logic [8:0]  ov_data;
    logic [31:0] mem [64];
    logic [8:0]  exp_q [$];
    int          tests = 0, fails = 0, total_rd = 0, rd_frame = 0, fb = 0, max_out = 0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_data = '0;
`ifdef HCP_RSP_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    hcp_rd_rsp dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_req    (i_rd_req),
        .iv_rd_addr  (iv_rd_addr),
        .iv_rd_num   (iv_rd_num),
        .o_busy      (o_busy),
        .o_req_drop  (o_req_drop),
        .ov_ram_addr (ov_ram_addr),
        .o_ram_rden  (o_ram_rden),
        .iv_ram_q    (iv_ram_q),
        .ov_data     (ov_data),
        .o_data_wr   (o_data_wr),
        .i_ready     (i_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_r1   <= mem[ov_ram_addr];
        iv_ram_q <= ram_r1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void push_frame(input logic [5:0] a, input logic [5:0] n);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [5:0]  ad;
        exp_q.push_back(9'h102);
        exp_q.push_back({3'b0, a});
        exp_q.push_back({3'b0, n});
        cs = 8'h02 ^ {2'b0, a} ^ {2'b0, n};
        ad = a;
        for (int k = 0; k < int'(n); k++) begin
            w = mem[ad];
            for (int j = 3; j >= 0; j--) begin
                exp_q.push_back({1'b0, w[8*j +: 8]});
                cs = cs ^ w[8*j +: 8];
            end
            ad = ad + 6'd1;
        end
`ifdef HCP_RSP_CSUM_EN
        exp_q.push_back({1'b0, cs});
`endif
    endfunction

    task automatic req(input logic [5:0] a, input logic [5:0] n);
        i_rd_req   = 1'b1;
        iv_rd_addr = a;
        iv_rd_num  = n;
        push_frame(a, n);
        tick;
        i_rd_req = 1'b0;
    endtask

    // Called in cycle T+1; nb is the frame length, so with i_ready high o_busy must fall at T+nb+1.
    task automatic run_frame(input string name, input int nb, input bit rnd);
        int c = 1;
        while (o_busy && c < 400) begin
            if (rnd) i_ready = 1'($urandom_range(0, 1));
            tick;
            c++;
        end
        i_ready = 1'b1;
        if (!rnd) chk({name, "_len"}, c, nb + 1);
        chk({name, "_done"}, o_busy, 1'b0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        int         dd;
        if (o_ram_rden) begin
            total_rd++;
            rd_frame++;
        end
        if (!o_busy) begin
            rd_frame = 0;
            fb       = 0;
        end
        if (prev_stall) begin
            tests++;
            if (!(o_data_wr && ov_data == prev_data)) begin
                fails++;
                $display("FAIL stall_hold: got wr=%0b data=0x%0h expected wr=1 data=0x%0h", o_data_wr, ov_data, prev_data);
            end
        end
        if (o_data_wr && i_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL byte: got 0x%0h expected none", ov_data);
            end else begin
                e = exp_q.pop_front();
                if (ov_data !== e) begin
                    fails++;
                    $display("FAIL byte: got 0x%0h expected 0x%0h", ov_data, e);
                end
            end
            fb = ov_data[8] ? 1 : fb + 1;
        end
        dd = fb > 3 ? (fb - 3) / 4 : 0;
        if (rd_frame - dd > max_out) max_out = rd_frame - dd;
        prev_stall = o_data_wr && !i_ready;
        prev_data  = ov_data;
    end

    initial begin
        int rd0;
        int nb;
        for (int i = 0; i < 64; i++)
            mem[i] = (i == 0) ? 32'h0 : {8'(i), 8'(3 * i), 8'(8'hA5 ^ 8'(i)), 8'(240 - i)};
        rst = 1'b1;
        i_rd_req = 1'b0;
        iv_rd_addr = '0;
        iv_rd_num = '0;
        i_ready = 1'b1;
        repeat (3) tick;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_drop", o_req_drop, 1'b0);
        chk("rst_wr", o_data_wr, 1'b0);
        chk("rst_data", ov_data, 9'h0);
        chk("rst_ram_addr", ov_ram_addr, 6'h0);
        chk("rst_rden", o_ram_rden, 1'b0);
        rst = 1'b0;
        tick;

        rd0 = total_rd;
        req(6'd5, 6'd1);
        chk("t1_first_byte", ov_data, 9'h102);
        chk("t1_busy", o_busy, 1'b1);
        run_frame("t1", 7 + CS, 1'b0);
        chk("t1_reads", total_rd - rd0, 1);

        rd0 = total_rd;
        req(6'd62, 6'd4);
        run_frame("t2", 19 + CS, 1'b0);
        chk("t2_reads", total_rd - rd0, 4);

        rd0 = total_rd;
        req(6'd9, 6'd0);
        run_frame("t3", 3 + CS, 1'b0);
        chk("t3_reads", total_rd - rd0, 0);

        rd0 = total_rd;
        req(6'd10, 6'd8);
        run_frame("t4", 35 + CS, 1'b1);
        chk("t4_reads", total_rd - rd0, 8);

        rd0 = total_rd;
        nb = 11 + CS;
        req(6'd30, 6'd2);
        tick;
        tick;
        i_rd_req = 1'b1;
        iv_rd_addr = 6'd7;
        iv_rd_num = 6'd7;
        tick;
        i_rd_req = 1'b0;
        chk("t5_drop_busy", o_req_drop, 1'b1);
        tick;
        chk("t5_drop_pulse", o_req_drop, 1'b0);
        repeat (nb - 5) tick;
        chk("t5_busy_last", o_busy, 1'b1);
        i_rd_req = 1'b1;
        tick;
        chk("t5_drop_last", o_req_drop, 1'b1);
        chk("t5_idle", o_busy, 1'b0);
        chk("t5_reads", total_rd - rd0, 2);
        chk("t5_sb_empty", exp_q.size(), 0);
        rd0 = total_rd;
        req(6'd40, 6'd1);
        run_frame("t5b", 7 + CS, 1'b0);
        chk("t5b_reads", total_rd - rd0, 1);

        req(6'd20, 6'd3);
        repeat (5) tick;
        rst = 1'b1;
        tick;
        chk("t6_rst_wr", o_data_wr, 1'b0);
        chk("t6_rst_data", ov_data, 9'h0);
        chk("t6_rst_busy", o_busy, 1'b0);
        chk("t6_rst_rden", o_ram_rden, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        tick;
        rd0 = total_rd;
        req(6'd0, 6'd1);
        run_frame("t6", 7 + CS, 1'b0);
        chk("t6_reads", total_rd - rd0, 1);

        chk("reads_ahead_le3", 32'(max_out <= 3), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
